shift_exec_stage: RTL and testbench

- Registered execution stage wrapped around the existing combinational 32-bit shifter SHIFT32.
- Accepts shift requests over a valid/ready handshake and latches the operands.
- Time-shares one SHIFT32 instance over one or two passes, and holds the result in an output register until it is consumed.
- Adds rotate operations built from two opposite-direction shifts, plus a completed-operation counter.

---
 rtl/shift_exec_stage.sv | 123 ++++++++++++
 tb/tb_shift_exec_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - registered shift/rotate execution stage around a shared 32-bit shifter
module shift32 (
    input  logic [31:0] d,
    input  logic [31:0] s,
    input  logic        lnr,
    output logic [31:0] y
);
    // Any amount of 32 or more shifts every bit out.
    always_comb begin
        y = '0;
        if (s[31:5] == 27'd0) begin
            y = lnr ? (d << s[4:0]) : (d >> s[4:0]);
        end
    end
endmodule

module shift_exec_stage #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [31:0]          D,
    input  logic [31:0]          S,
    input  logic [1:0]           OP,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [31:0]          Y,
    output logic [CNT_WIDTH-1:0] OP_CNT
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t               state;
    logic [31:0]          r_d;
    logic [31:0]          r_s;
    logic [1:0]           r_op;
    logic [31:0]          r_y;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic        accept;
    logic        is_rot;
    logic        first_left;
    logic        sh_lnr;
    logic [31:0] sh_s;
    logic [31:0] sh_y;

    assign IN_READY   = (state == IDLE) || ((state == DONE) && OUT_READY);
    assign accept     = IN_VALID && IN_READY;
    assign is_rot     = r_op[1];
    assign first_left = ~r_op[0];

    // Rotates use only the low 5 amount bits; the second pass fills in the wrapped bits.
    always_comb begin
        sh_lnr = first_left;
        sh_s   = is_rot ? {27'd0, r_s[4:0]} : r_s;
        if (state == PASS2) begin
            sh_lnr = ~first_left;
            sh_s   = 32'd32 - {27'd0, r_s[4:0]};
        end
    end

    shift32 u_shift32 (
        .d   (r_d),
        .s   (sh_s),
        .lnr (sh_lnr),
        .y   (sh_y)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            r_d         <= '0;
            r_s         <= '0;
            r_op        <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (r_out_valid && OUT_READY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (accept) begin
                r_d  <= D;
                r_s  <= S;
                r_op <= OP;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= PASS1;
                    end
                end
                PASS1: begin
                    r_y <= sh_y;
                    if (is_rot) begin
                        state <= PASS2;
                    end else begin
                        state       <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                PASS2: begin
                    r_y         <= r_y | sh_y;
                    state       <= DONE;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        state       <= IN_VALID ? PASS1 : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OUT_VALID = r_out_valid;
    assign Y         = r_y;
    assign OP_CNT    = r_cnt;
endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - self-checking bench for shift_exec_stage
module tb_shift_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_d = '0;
    logic [31:0] in_s = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] y;
    logic [15:0] op_cnt;

    int checks = 0;
    int passes = 0;

    shift_exec_stage #(.CNT_WIDTH(16)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .D         (in_d),
        .S         (in_s),
        .OP        (in_op),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .Y         (y),
        .OP_CNT    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] d, input logic [31:0] s,
                                               input logic [1:0] op);
        logic [63:0] t;
        int unsigned a;
        a = s % 32;
        case (op)
            2'b00: return (s > 31) ? 32'd0 : (d << s);
            2'b01: return (s > 31) ? 32'd0 : (d >> s);
            2'b10: begin t = {d, d} << a; return t[63:32]; end
            default: begin t = {d, d} >> a; return t[31:0]; end
        endcase
    endfunction

    // Transaction-level model: pending result, cycles until it appears, output slot.
    logic        m_valid = 1'b0;
    logic [31:0] m_y = '0;
    logic [31:0] m_pend = '0;
    logic [15:0] m_cnt = '0;
    int          m_rem = 0;
    int          m_acc_cnt = 0;

    function automatic logic m_in_ready();
        return (m_rem == 0) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic acc;
        if (!rst_n) begin
            m_valid = 1'b0; m_y = '0; m_cnt = '0; m_rem = 0;
        end else begin
            acc = in_valid && m_in_ready();
            if (m_valid && out_ready) begin
                m_cnt++;
                m_valid = 1'b0;
            end
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_valid = 1'b1;
                    m_y = m_pend;
                end
            end
            if (acc) begin
                m_pend = ref_result(in_d, in_s, in_op);
                m_rem = in_op[1] ? 2 : 1;
                m_acc_cnt++;
            end
        end
    end

    int cyc = 0;
    logic prev_ov = 1'b0;
    int rise_cyc[$];
    logic [31:0] rise_y[$];

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("in_ready", 32'(in_ready), 32'(m_in_ready()));
            check("op_cnt", 32'(op_cnt), 32'(m_cnt));
            if (m_rem == 0) check("y", y, m_y);
            if (out_valid && !prev_ov) begin
                rise_cyc.push_back(cyc);
                rise_y.push_back(y);
            end
        end
        prev_ov = out_valid;
    end

    task automatic present(input logic [31:0] d, input logic [31:0] s, input logic [1:0] op);
        int n0;
        int k;
        n0 = m_acc_cnt;
        #1;
        in_valid = 1'b1; in_d = d; in_s = s; in_op = op;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (m_acc_cnt != n0) break;
        end
        if (k == 20) check("accept_timeout", 32'(k), 32'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] d, input logic [31:0] s,
                          input logic [1:0] op, input logic [31:0] exp_y, input int exp_lat);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        present(d, s, op);
        #1 in_valid = 1'b0;
        for (lat = 1; lat < 10; lat++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_y"}, y, exp_y);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] cnt_before;
        int acc_before;

        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_y", y, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op("sll_4",     32'h0000_0001, 32'd4,         2'b00, 32'h0000_0010, 1);
        run_op("srl_31",    32'h8000_0000, 32'd31,        2'b01, 32'h0000_0001, 1);
        run_op("sll_32",    32'hFFFF_FFFF, 32'd32,        2'b00, 32'h0000_0000, 1);
        run_op("srl_100",   32'hFFFF_FFFF, 32'h0000_0100, 2'b01, 32'h0000_0000, 1);
        run_op("rol_1",     32'h8000_0001, 32'd1,         2'b10, 32'h0000_0003, 2);
        run_op("ror_4",     32'h0000_0001, 32'd4,         2'b11, 32'h1000_0000, 2);
        run_op("rol_32",    32'h1234_5678, 32'd32,        2'b10, 32'h1234_5678, 2);
        run_op("ror_36",    32'h1234_5678, 32'd36,        2'b11, 32'h8123_4567, 2);
        run_op("sll_0",     32'hA5A5_A5A5, 32'd0,         2'b00, 32'hA5A5_A5A5, 1);
        run_op("srl_big",   32'hFFFF_FFFF, 32'h8000_0001, 2'b01, 32'h0000_0000, 1);

        // Back-to-back with the request held valid.
        @(negedge clk);
        do_reset();
        @(negedge clk);
        rise_cyc.delete();
        rise_y.delete();
        out_ready = 1'b1;
        present(32'h0000_0001, 32'd3, 2'b00);
        present(32'h0000_00F0, 32'd8, 2'b11);
        present(32'h8000_0000, 32'd4, 2'b01);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_pulses", 32'(rise_cyc.size()), 32'd3);
        if (rise_cyc.size() == 3) begin
            check("b2b_gap1", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
            check("b2b_gap2", 32'(rise_cyc[2] - rise_cyc[1]), 32'd2);
            check("b2b_y0", rise_y[0], 32'h0000_0008);
            check("b2b_y1", rise_y[1], 32'hF000_0000);
            check("b2b_y2", rise_y[2], 32'h0800_0000);
        end
        check("b2b_op_cnt", 32'(op_cnt), 32'd3);

        // Backpressure in DONE with a pending request.
        #1 out_ready = 1'b0;
        present(32'h0000_0003, 32'd1, 2'b00);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) @(negedge clk);
        #1;
        in_valid = 1'b1; in_d = 32'h0000_00F0; in_s = 32'd4; in_op = 2'b01;
        acc_before = m_acc_cnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_y", y, 32'h0000_0006);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        check("bp_no_accept", 32'(m_acc_cnt), 32'(acc_before));
        cnt_before = op_cnt;
        check("bp_cnt_hold", 32'(cnt_before), 32'd3);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_accept", 32'(m_acc_cnt), 32'(acc_before + 1));
        check("bp_cnt_inc", 32'(op_cnt), 32'd4);
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_y2", y, 32'h0000_000F);

        // Reset during the second pass of a rotate.
        @(negedge clk);
        present(32'h0000_0001, 32'd4, 2'b11);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", y, 32'd0);
        check("mid_rst_cnt", 32'(op_cnt), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        rise_cyc.delete();
        repeat (5) @(negedge clk);
        check("no_stale", 32'(rise_cyc.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
